// File: rtl/sys_ram.sv
`default_nettype none
// ============================================================================
// Module   : sys_ram
// Summary  : Two-port system RAM (CPU read/write, DMA read-only) with fixed
//            DMA priority, LAT-deep read pipeline, ROM write protection and a
//            post-reset hardware clear sequence.
// Revision : 1.0
// ============================================================================
module sys_ram #(
    parameter int              AW             = 16,
    parameter int              DW             = 8,
    parameter int              LAT            = 1,
    parameter logic [AW-1:0]   ROM_BASE       = AW'(16'hA000),
    parameter logic [AW-1:0]   ROM_TOP        = AW'(16'hBFFF),
    parameter bit              CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_ab,
    input  logic [DW-1:0] cpu_do,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_di,
    output logic          cpu_rvalid,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_ab,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_di,
    output logic          dma_rvalid,
    output logic          busy,
    output logic          wp_err
);

    // ST_IDLE only exists without a clear: it keeps grants low while reset is held.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam state_t        c_RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    localparam logic [AW-1:0] c_LAST_ADDR = '1;

    logic [DW-1:0] r_mem [0:(2**AW)-1];

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_clr_addr, w_clr_addr_nxt;

    logic          w_run, w_dma_acc, w_cpu_acc, w_cpu_wr, w_in_rom;
    logic          w_rd_acc, w_rd_cpu;
    logic [AW-1:0] w_rd_addr;
    logic [DW-1:0] w_rd_dat;
    logic          w_fin_vld, w_fin_cpu;
    logic [DW-1:0] w_fin_dat;

    logic          r_cpu_rvalid, r_dma_rvalid, r_wp_err;
    logic [DW-1:0] r_cpu_di, r_dma_di;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_RST_STATE;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_RUN;
            ST_CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                if (r_clr_addr == c_LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default:  w_state_nxt = r_state;
        endcase
    end

    assign w_run     = (r_state == ST_RUN);
    assign w_dma_acc = w_run & dma_req;
    assign w_cpu_acc = w_run & cpu_req & ~dma_req;
    assign w_cpu_wr  = w_cpu_acc & cpu_we;
    assign w_in_rom  = (cpu_ab >= ROM_BASE) && (cpu_ab <= ROM_TOP);

    assign w_rd_acc  = w_dma_acc | (w_cpu_acc & ~cpu_we);
    assign w_rd_cpu  = ~w_dma_acc;
    assign w_rd_addr = w_dma_acc ? dma_ab : cpu_ab;
    assign w_rd_dat  = r_mem[w_rd_addr];

    // Array has no reset; only the clear sequence initialises it.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_addr] <= '0;
        end else if (w_cpu_wr && !w_in_rom) begin
            r_mem[cpu_ab] <= cpu_do;
        end
    end

    generate
        if (LAT == 1) begin : g_lat1
            assign w_fin_vld = w_rd_acc;
            assign w_fin_cpu = w_rd_cpu;
            assign w_fin_dat = w_rd_dat;
        end else begin : g_latn
            logic [LAT-2:0] r_pv, r_pc;
            logic [DW-1:0]  r_pd [LAT-1];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_pv <= '0;
                    r_pc <= '0;
                    for (int i = 0; i < LAT-1; i++) begin
                        r_pd[i] <= '0;
                    end
                end else begin
                    r_pv[0] <= w_rd_acc;
                    r_pc[0] <= w_rd_cpu;
                    r_pd[0] <= w_rd_dat;
                    for (int i = 1; i < LAT-1; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_pc[i] <= r_pc[i-1];
                        r_pd[i] <= r_pd[i-1];
                    end
                end
            end

            assign w_fin_vld = r_pv[LAT-2];
            assign w_fin_cpu = r_pc[LAT-2];
            assign w_fin_dat = r_pd[LAT-2];
        end
    endgenerate

    // Last pipeline stage lands in per-port holding registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_cpu_di     <= '0;
            r_dma_di     <= '0;
            r_wp_err     <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_fin_vld & w_fin_cpu;
            r_dma_rvalid <= w_fin_vld & ~w_fin_cpu;
            if (w_fin_vld && w_fin_cpu) begin
                r_cpu_di <= w_fin_dat;
            end
            if (w_fin_vld && !w_fin_cpu) begin
                r_dma_di <= w_fin_dat;
            end
            r_wp_err <= w_cpu_wr & w_in_rom;
        end
    end

    assign cpu_gnt    = w_cpu_acc;
    assign dma_gnt    = w_dma_acc;
    assign cpu_di     = r_cpu_di;
    assign dma_di     = r_dma_di;
    assign cpu_rvalid = r_cpu_rvalid;
    assign dma_rvalid = r_dma_rvalid;
    assign busy       = (r_state == ST_CLEAR);
    assign wp_err     = r_wp_err;

endmodule
`default_nettype wire
